// File: rtl/uxut_seq.sv
// Sequencer that streams three sample rows from memory through one shared
// signed multiplier and returns the six unique terms of the symmetric product u*u^T.
module uxut_seq #(
  parameter int N  = 64,
  parameter int DW = 32,
  parameter int AW = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        mem_rd,
  output logic [$clog2(N)+1:0]        mem_addr,
  input  logic signed [DW-1:0]        mem_data,
  output logic                        busy,
  output logic                        res_valid,
  output logic [2:0]                  res_idx,
  output logic signed [AW-1:0]        res,
  output logic                        done
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, OUT, FIN} state_t;

  state_t                state, state_n;
  logic [IW-1:0]         k;
  logic [3:0]            phase;
  logic [2:0]            out_cnt;
  logic signed [DW-1:0]  x0, x1, x2;
  logic signed [AW-1:0]  acc [6];

  logic signed [DW-1:0]   mul_a, mul_b;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_ext;
  logic [2:0]             mac_sel;
  logic                   mac_en;

  wire last_k = (k == IW'(N - 1));

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = RUN;
      RUN:  if (phase == 4'd8 && last_k) state_n = OUT;
      OUT:  if (out_cnt == 3'd5) state_n = FIN;
      FIN:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // MAC order (0,0),(0,1),(1,1),(0,2),(1,2),(2,2); mac_sel is the result index of each term.
  always_comb begin
    mul_a   = '0;
    mul_b   = '0;
    mac_sel = 3'd0;
    mac_en  = 1'b0;
    if (state == RUN) begin
      unique case (phase)
        4'd3: begin mul_a = x0; mul_b = x0; mac_sel = 3'd0; mac_en = 1'b1; end
        4'd4: begin mul_a = x0; mul_b = x1; mac_sel = 3'd1; mac_en = 1'b1; end
        4'd5: begin mul_a = x1; mul_b = x1; mac_sel = 3'd3; mac_en = 1'b1; end
        4'd6: begin mul_a = x0; mul_b = x2; mac_sel = 3'd2; mac_en = 1'b1; end
        4'd7: begin mul_a = x1; mul_b = x2; mac_sel = 3'd4; mac_en = 1'b1; end
        4'd8: begin mul_a = x2; mul_b = x2; mac_sel = 3'd5; mac_en = 1'b1; end
        default: ;
      endcase
    end
  end

  assign prod     = mul_a * mul_b;
  assign prod_ext = AW'(prod);

  always_comb begin
    mem_rd    = (state == RUN) && (phase < 4'd3);
    mem_addr  = mem_rd ? {phase[1:0], k} : '0;
    busy      = (state == RUN) || (state == OUT);
    done      = (state == FIN);
    res_valid = (state == OUT);
    res_idx   = res_valid ? out_cnt : 3'd0;
    res       = res_valid ? acc[out_cnt] : '0;
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      phase   <= '0;
      out_cnt <= '0;
      x0      <= '0;
      x1      <= '0;
      x2      <= '0;
      // NOTE: the accumulator array is explicitly reset because its contents are visible as results.
      for (int i = 0; i < 6; i++) acc[i] <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 6; i++) acc[i] <= '0;
            k       <= '0;
            phase   <= '0;
            out_cnt <= '0;
          end
        end
        RUN: begin
          // Read data arrives one cycle after its strobe.
          if (phase == 4'd1) x0 <= mem_data;
          if (phase == 4'd2) x1 <= mem_data;
          if (phase == 4'd3) x2 <= mem_data;
          if (mac_en) acc[mac_sel] <= acc[mac_sel] + prod_ext;
          if (phase == 4'd8) begin
            phase <= '0;
            k     <= last_k ? '0 : k + IW'(1);
          end else begin
            phase <= phase + 4'd1;
          end
        end
        OUT: out_cnt <= (out_cnt == 3'd5) ? 3'd0 : out_cnt + 3'd1;
        FIN: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uxut_seq.sv
// Self-checking bench for uxut_seq: memory responder, per-cycle protocol checks
// and a sum-of-products reference computed directly from the sample rows.
module tb_uxut_seq;

  localparam int N  = 64;
  localparam int DW = 32;
  localparam int AW = 64;
  localparam int IW = $clog2(N);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 mem_rd;
  logic [IW+1:0]        mem_addr;
  logic signed [DW-1:0] mem_data = '0;
  logic                 busy;
  logic                 res_valid;
  logic [2:0]           res_idx;
  logic signed [AW-1:0] res;
  logic                 done;

  uxut_seq #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .busy      (busy),
    .res_valid (res_valid),
    .res_idx   (res_idx),
    .res       (res),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic signed [DW-1:0] mem [0:3][0:N-1];
  logic                 rd_n = 1'b0;
  logic [IW+1:0]        addr_n = '0;

  // Memory responder: data for a strobe seen in a cycle appears just after the closing edge.
  always @(negedge clk) begin
    rd_n   = mem_rd;
    addr_n = mem_addr;
  end
  always @(posedge clk) begin
    #1 mem_data = rd_n ? mem[addr_n[IW+1:IW]][addr_n[IW-1:0]] : '0;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [63:0] exp_r [6];

  // Reference: r_ij = sum_k u_i[k]*u_j[k], wrapped to 64 bits.
  task automatic compute_ref();
    int pi [6] = '{0, 0, 0, 1, 1, 2};
    int pj [6] = '{0, 1, 2, 1, 2, 2};
    for (int r = 0; r < 6; r++) begin
      longint s = 0;
      for (int i = 0; i < N; i++)
        s += longint'(mem[pi[r]][i]) * longint'(mem[pj[r]][i]);
      exp_r[r] = s;
    end
  endtask

  // mode 0: all ones, 1: u0=k, 2: -1/1/2, 3: max positive in row 0, 4: random
  task automatic fill(input int mode);
    for (int i = 0; i < N; i++) begin
      for (int r = 0; r < 4; r++) mem[r][i] = $urandom();
      case (mode)
        0: begin mem[0][i] = 1;             mem[1][i] = 1; mem[2][i] = 1; end
        1: begin mem[0][i] = i;             mem[1][i] = 0; mem[2][i] = 0; end
        2: begin mem[0][i] = -1;            mem[1][i] = 1; mem[2][i] = 2; end
        3: begin mem[0][i] = 32'h7FFF_FFFF; mem[1][i] = 0; mem[2][i] = 0; end
        default: ;
      endcase
    end
    compute_ref();
  endtask

  // Runs one job, entered at the falling edge of an IDLE cycle (cycle 0).
  // restart_cyc: cycle in which a spurious start is driven; fin_start: drive start in FIN;
  // abort_cyc: cycle in which rst is raised (0 = none).
  task automatic job(input string name, input int restart_cyc, input bit fin_start, input int abort_cyc);
    int last_cyc = (abort_cyc > 0) ? abort_cyc + 12 : 584;
    start = 1'b1;
    for (int cyc = 1; cyc <= last_cyc; cyc++) begin
      bit ab;
      bit e_rd, e_valid;
      int ph, kk;
      logic [63:0] e_addr, e_res;
      logic [2:0]  e_idx;
      @(negedge clk);
      start = 1'b0;
      ab = (abort_cyc > 0) && (cyc > abort_cyc);
      ph = (cyc - 1) % 9;
      kk = (cyc - 1) / 9;
      e_rd    = !ab && cyc <= 9 * N && ph < 3;
      e_addr  = e_rd ? 64'((ph << IW) | kk) : 64'd0;
      e_valid = !ab && cyc >= 9 * N + 1 && cyc <= 9 * N + 6;
      e_idx   = e_valid ? 3'(cyc - 9 * N - 1) : 3'd0;
      e_res   = e_valid ? exp_r[cyc - 9 * N - 1] : 64'd0;
      check({name, ".busy"},      64'(busy),      64'(!ab && cyc <= 9 * N + 6));
      check({name, ".done"},      64'(done),      64'(!ab && cyc == 9 * N + 7));
      check({name, ".mem_rd"},    64'(mem_rd),    64'(e_rd));
      check({name, ".mem_addr"},  64'(mem_addr),  e_addr);
      check({name, ".res_valid"}, 64'(res_valid), 64'(e_valid));
      check({name, ".res_idx"},   64'(res_idx),   64'(e_idx));
      check({name, ".res"},       64'(res),       e_res);
      if (cyc == restart_cyc) start = 1'b1;
      if (fin_start && cyc == 9 * N + 7) start = 1'b1;
      if (abort_cyc > 0 && cyc == abort_cyc) rst = 1'b1;
      if (abort_cyc > 0 && cyc == abort_cyc + 1) rst = 1'b0;
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    fill(0);
    repeat (3) @(negedge clk);
    check("reset.busy",      64'(busy),      64'd0);
    check("reset.done",      64'(done),      64'd0);
    check("reset.res_valid", 64'(res_valid), 64'd0);
    check("reset.mem_rd",    64'(mem_rd),    64'd0);
    check("reset.mem_addr",  64'(mem_addr),  64'd0);
    check("reset.res_idx",   64'(res_idx),   64'd0);
    check("reset.res",       64'(res),       64'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle.busy", 64'(busy), 64'd0);

    fill(0); job("ones",   0, 1'b0, 0);
    fill(1); job("ramp",   0, 1'b0, 0);
    fill(2); job("signs",  0, 1'b1, 0);
    fill(3); job("maxpos", 0, 1'b0, 0);
    fill(0); job("abort",  0, 1'b0, 1 + 9 * 10 + 3);
    job("fresh", 0, 1'b0, 0);
    fill(4); job("rand_restart", 100, 1'b0, 0);
    fill(4); job("rand", 0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
